// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory between instruction fetch and data.
// Data normally wins; a fetch that has been starved MAX_WAIT cycles takes the next slot.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    input  logic                  if_flush,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [3:0]            d_req_we,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_t;

    localparam logic [3:0] MAX_WAIT_CNT = 4'(MAX_WAIT);

    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  rsp_valid;
    owner_t                rsp_owner;
    logic                  rsp_is_write;
    logic                  fetch_prio;
    logic                  if_fire;
    logic                  d_fire;
    logic                  fetch_rsp;
    logic                  data_rsp;

    // A flushed fetch cannot fire, so it never steals the slot from data.
    always_comb begin
        fetch_prio   = if_req_valid && !if_flush && (wait_cnt == MAX_WAIT_CNT);
        if_req_ready = !reset && !if_flush && (fetch_prio || !d_req_valid);
        d_req_ready  = !reset && !fetch_prio;
        if_fire      = if_req_valid && if_req_ready;
        d_fire       = d_req_valid && d_req_ready;
    end

    always_comb begin
        mem_addr  = last_addr;
        mem_we    = '0;
        mem_wdata = '0;
        if (reset) begin
            mem_addr = '0;
        end else if (if_fire) begin
            mem_addr = if_req_addr;
        end else if (d_fire) begin
            mem_addr  = d_req_addr;
            mem_we    = d_req_we;
            mem_wdata = d_req_wdata;
        end
    end

    // Reset and flush gate the registered response so nothing stale leaks out.
    always_comb begin
        fetch_rsp    = rsp_valid && (rsp_owner == OWNER_FETCH) && !reset && !if_flush;
        data_rsp     = rsp_valid && (rsp_owner == OWNER_DATA) && !reset;
        if_rsp_valid = fetch_rsp;
        if_rsp_data  = fetch_rsp ? mem_rdata : '0;
        d_rsp_valid  = data_rsp;
        d_rsp_data   = (data_rsp && !rsp_is_write) ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt     <= '0;
            last_addr    <= '0;
            rsp_valid    <= 1'b0;
            rsp_owner    <= OWNER_FETCH;
            rsp_is_write <= 1'b0;
        end else begin
            if (!if_req_valid || if_flush || if_fire) begin
                wait_cnt <= '0;
            end else if (wait_cnt < MAX_WAIT_CNT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            rsp_valid    <= if_fire || d_fire;
            rsp_owner    <= if_fire ? OWNER_FETCH : OWNER_DATA;
            rsp_is_write <= d_fire && (d_req_we != 4'b0000);
            if (if_fire || d_fire) begin
                last_addr <= mem_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus for mem_port_arbiter, checked against a transaction-level
// model: who wins each cycle, a reference memory image and a one-slot response queue.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req_valid = 1'b0;
    logic [AW-1:0] if_req_addr = '0;
    logic          if_req_ready;
    logic          if_flush = 1'b0;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rsp_data;
    logic          d_req_valid = 1'b0;
    logic [AW-1:0] d_req_addr = '0;
    logic [3:0]    d_req_we = '0;
    logic [DW-1:0] d_req_wdata = '0;
    logic          d_req_ready;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 4) return 32'h00500093;
        return (32'h9E3779B9 * 32'(a + 1)) ^ 32'h5A5A5A5A;
    endfunction

    // Synchronous memory the arbiter drives: read data one cycle after the address.
    logic          preload = 1'b1;
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        logic [DW-1:0] cur;
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
        end else begin
            cur = ram[mem_addr];
            mem_rdata <= cur;
            if (mem_we != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
                ram[mem_addr] <= cur;
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            starve;
    logic [AW-1:0] ref_last_addr;
    bit            pend_valid;
    bit            pend_fetch;
    logic [DW-1:0] pend_data;

    int num_checks = 0;
    int num_fail = 0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle, checks every visible output against the model, then advances the model.
    task automatic applyStimulus(input bit rst, input bit ifv, input logic [AW-1:0] ifa, input bit fl,
                                 input bit dv, input logic [AW-1:0] da, input logic [3:0] dwe,
                                 input logic [DW-1:0] dwd);
        int winner;
        bit exp_if_rv, exp_d_rv;
        @(negedge clk);
        reset = rst; if_req_valid = ifv; if_req_addr = ifa; if_flush = fl;
        d_req_valid = dv; d_req_addr = da; d_req_we = dwe; d_req_wdata = dwd;
        #1;
        winner = 0;
        if (!rst) begin
            if (ifv && !fl && (!dv || starve >= MW)) winner = 1;
            else if (dv) winner = 2;
        end
        if (ifv || fl || rst) checkOutput("if_req_ready", 32'(if_req_ready), 32'(winner == 1));
        if (dv || rst) checkOutput("d_req_ready", 32'(d_req_ready), 32'(winner == 2));
        case (winner)
            1: begin
                checkOutput("mem_addr_fetch", 32'(mem_addr), 32'(ifa));
                checkOutput("mem_we_fetch", 32'(mem_we), 32'd0);
            end
            2: begin
                checkOutput("mem_addr_data", 32'(mem_addr), 32'(da));
                checkOutput("mem_we_data", 32'(mem_we), 32'(dwe));
                if (dwe != 4'b0000) checkOutput("mem_wdata", mem_wdata, dwd);
            end
            default: begin
                checkOutput("mem_addr_idle", 32'(mem_addr), rst ? 32'd0 : 32'(ref_last_addr));
                checkOutput("mem_we_idle", 32'(mem_we), 32'd0);
            end
        endcase
        exp_if_rv = pend_valid && pend_fetch && !rst && !fl;
        exp_d_rv  = pend_valid && !pend_fetch && !rst;
        checkOutput("if_rsp_valid", 32'(if_rsp_valid), 32'(exp_if_rv));
        checkOutput("if_rsp_data", if_rsp_data, exp_if_rv ? pend_data : '0);
        checkOutput("d_rsp_valid", 32'(d_rsp_valid), 32'(exp_d_rv));
        checkOutput("d_rsp_data", d_rsp_data, exp_d_rv ? pend_data : '0);

        pend_valid = (winner != 0);
        pend_fetch = (winner == 1);
        if (rst) begin
            starve = 0;
            ref_last_addr = '0;
        end else begin
            if (!ifv || fl || winner == 1) starve = 0;
            else if (starve < MW) starve++;
        end
        if (winner == 1) begin
            pend_data = ref_mem[ifa];
            ref_last_addr = ifa;
        end else if (winner == 2) begin
            pend_data = (dwe == 4'b0000) ? ref_mem[da] : '0;
            for (int b = 0; b < 4; b++)
                if (dwe[b]) ref_mem[da][b*8 +: 8] = dwd[b*8 +: 8];
            ref_last_addr = da;
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, '0, 0, 0, '0, 4'b0000, '0);
    endtask

    initial begin
        bit            h_ifv, h_dv, rst, fl;
        logic [AW-1:0] h_ifa, h_da;
        logic [3:0]    h_dwe;
        logic [DW-1:0] h_dwd;
        int            acks, stores;

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
        starve = 0; ref_last_addr = '0; pend_valid = 0; pend_fetch = 0; pend_data = '0;

        applyStimulus(1, 0, '0, 0, 0, '0, 4'b0000, '0);
        preload = 1'b0;
        applyStimulus(1, 1, 10'h004, 0, 1, 10'h008, 4'b1111, 32'h1);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        idleCycle();
        checkOutput("post_reset_wait_cnt", 32'(dut.wait_cnt), 32'd0);

        // Lone fetch: granted immediately, data one cycle later.
        applyStimulus(0, 1, 10'h004, 0, 0, '0, 4'b0000, '0);
        checkOutput("lone_fetch_ready", 32'(if_req_ready), 32'd1);
        idleCycle();
        checkOutput("lone_fetch_rsp", if_rsp_data, 32'h00500093);

        // Contention: data wins four cycles, then the starved fetch gets one slot.
        acks = 0; stores = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 10'h008, 0, 1, 10'(32 + stores), 4'b1111, $urandom);
            checkOutput("prio_pattern", 32'(if_req_ready), 32'((i % 5) == 4));
            if (d_rsp_valid) acks++;
            if (d_req_ready) stores++;
        end
        idleCycle();
        if (d_rsp_valid) acks++;
        checkOutput("store_acks", 32'(acks), 32'd8);

        // Byte-lane store then load of the same word.
        applyStimulus(0, 0, '0, 0, 1, 10'h010, 4'b0010, 32'h0000AB00);
        checkOutput("byte_store_we", 32'(mem_we), 32'h2);
        applyStimulus(0, 0, '0, 0, 1, 10'h010, 4'b0000, '0);
        idleCycle();
        checkOutput("byte_load_lane1", 32'(d_rsp_data[15:8]), 32'hAB);

        // Flush right after a fetch fire squashes its response and the wait counter.
        applyStimulus(0, 1, 10'h00C, 0, 0, '0, 4'b0000, '0);
        applyStimulus(0, 1, 10'h00C, 1, 1, 10'h011, 4'b0000, '0);
        checkOutput("flush_rsp_valid", 32'(if_rsp_valid), 32'd0);
        checkOutput("flush_ready", 32'(if_req_ready), 32'd0);
        idleCycle();
        checkOutput("flush_wait_cnt", 32'(dut.wait_cnt), 32'd0);

        // Reset lands on the cycle after a fetch fire: nothing is delivered.
        applyStimulus(0, 1, 10'h004, 0, 0, '0, 4'b0000, '0);
        applyStimulus(1, 0, '0, 0, 1, 10'h010, 4'b0000, '0);
        idleCycle();
        checkOutput("post_reset_no_rsp", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);
        applyStimulus(0, 1, 10'h004, 0, 0, '0, 4'b0000, '0);
        idleCycle();
        checkOutput("post_reset_fetch", if_rsp_data, 32'h00500093);

        // Random traffic with requesters holding their request until it fires.
        h_ifv = 0; h_dv = 0; h_ifa = '0; h_da = '0; h_dwe = '0; h_dwd = '0;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) < 3);
            fl  = ($urandom_range(0, 99) < 8);
            if (!h_ifv) begin
                h_ifv = ($urandom_range(0, 99) < 65);
                h_ifa = 10'($urandom_range(0, 31));
            end
            if (!h_dv) begin
                h_dv  = ($urandom_range(0, 99) < 65);
                h_da  = 10'($urandom_range(0, 31));
                h_dwe = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom_range(1, 15));
                h_dwd = $urandom;
            end
            applyStimulus(rst, h_ifv, h_ifa, fl, h_dv, h_da, h_dwe, h_dwd);
            if (rst || fl || (h_ifv && if_req_ready)) h_ifv = 0;
            if (rst || (h_dv && d_req_ready)) h_dv = 0;
        end
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10: word-address width of the shared memory.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: data width of the memory and of both requesters.
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, legal range 1..15: consecutive denied fetch cycles before fetch gets priority.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 if_req_valid  in  1  instruction fetch request.
REQ-008 if_req_addr  in  ADDR_WIDTH  fetch word address.
REQ-009 if_req_ready  out  1  fetch request accepted this cycle.
REQ-010 if_flush  in  1  squash fetch traffic (taken branch/jump).
REQ-011 if_rsp_valid  out  1  fetch read data valid.
REQ-012 if_rsp_data  out  DATA_WIDTH  fetch read data.
REQ-013 d_req_valid  in  1  load/store request.
REQ-014 d_req_addr  in  ADDR_WIDTH  data word address.
REQ-015 d_req_we  in  4  byte write enables; 0 means read.
REQ-016 d_req_wdata  in  DATA_WIDTH  store data, already lane-aligned.
REQ-017 d_req_ready  out  1  data request accepted this cycle.
REQ-018 d_rsp_valid  out  1  load data valid or store acknowledge.
REQ-019 d_rsp_data  out  DATA_WIDTH  load data; 0 for a store acknowledge.
REQ-020 mem_addr  out  ADDR_WIDTH  shared memory address.
REQ-021 mem_we  out  4  shared memory byte write enables.
REQ-022 mem_wdata  out  DATA_WIDTH  shared memory write data.
REQ-023 mem_rdata  in  DATA_WIDTH  shared memory read data; synchronous, valid one cycle after the address is presented.

Function
REQ-024 A transfer SHALL fire on a port when valid=1 and ready=1 in the same cycle; at most one port fires per cycle.
REQ-025 Requesters SHALL hold valid, addr, we and wdata stable until fire; the arbiter SHALL NOT depend on ready to decide a requester's valid.
REQ-026 Default priority SHALL be data over fetch: if both valid and wait_cnt<MAX_WAIT, d_req_ready=1 and if_req_ready=0.
REQ-027 wait_cnt (4 bits) SHALL increment when if_req_valid=1, if_flush=0, and fetch is denied, saturating at MAX_WAIT; it SHALL clear on fetch fire, on if_req_valid=0, or on if_flush=1.
REQ-028 When wait_cnt==MAX_WAIT and if_req_valid=1, fetch SHALL win and data SHALL be denied that cycle.
REQ-029 A lone valid requester SHALL be granted in the same cycle (zero-cycle arbitration latency).
REQ-030 if_flush=1 SHALL force if_req_ready=0 that cycle and SHALL force if_rsp_valid=0 that cycle, discarding a fetch response due then; data traffic SHALL be unaffected.
REQ-031 mem_addr, mem_we and mem_wdata SHALL come combinationally from the firing port; with no fire, mem_we=0 and mem_addr holds its last fired value.
REQ-032 Fetch fire SHALL drive mem_we=0; data fire SHALL drive mem_we=d_req_we and mem_wdata=d_req_wdata.
REQ-033 A one-entry response register SHALL record {valid, owner, is_write} at each fire; the response SHALL appear exactly one cycle after fire for exactly one cycle.
REQ-034 Fetch response SHALL give if_rsp_data=mem_rdata. A data read response SHALL give d_rsp_data=mem_rdata. A data write response SHALL give d_rsp_data=0.
REQ-035 Response outputs of the non-owning port SHALL be valid=0, data=0.
REQ-036 Back-to-back fires SHALL be sustained every cycle (full throughput); there SHALL be no backpressure on responses.

Reset
REQ-037 While reset=1: if_req_ready=0, d_req_ready=0, mem_we=0, mem_addr=0, and no fire occurs.
REQ-038 After a reset edge: response register valid=0, wait_cnt=0, if_rsp_valid=d_rsp_valid=0, rsp data=0.
REQ-039 Reset asserted mid-operation SHALL drop any in-flight response; no response is delivered for a fire in the cycle before reset.

Verification
REQ-040 Only fetch valid, addr 0x004, mem word 0x00500093 -> if_req_ready=1 at t, if_rsp_valid=1 with data 0x00500093 at t+1.
REQ-041 Both valid every cycle, MAX_WAIT=4, store stream with we=4'b1111 -> data wins 4 cycles, fetch wins cycle 5, pattern repeats; no store lost; each store acknowledged with d_rsp_data=0.
REQ-042 Store with we=4'b0010, addr 0x010, wdata 0x0000AB00, then load from 0x010 -> mem_we=4'b0010 on the store cycle; load response shows byte 1 = 0xAB.
REQ-043 Fetch fires at t, if_flush=1 at t+1 -> if_rsp_valid=0 at t+1, if_req_ready=0 at t+1, wait_cnt=0 at t+2.
REQ-044 Fetch and load fire in consecutive cycles, reset=1 on the second -> no rsp_valid after reset; all outputs at reset values; first post-reset fetch completes normally.
